// File: rtl/register_file_pkg.sv
// Shared types and helpers for the locking register file.
package register_file_pkg;

  localparam int RF_ADDR_W = 5;
  localparam logic [RF_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rf_rd_state_e;

  // x0 and anything beyond the implemented words behave as a hard-wired zero register.
  function automatic logic is_null_reg(input logic [RF_ADDR_W-1:0] addr, input int num_words);
    return (addr == ZERO_REG) || (int'(addr) >= num_words);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: waits while the addressed register is locked, then captures and acks for one cycle.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_req,
  input  logic                 i_busy,
  input  logic [DataWidth-1:0] i_data,
  output logic                 o_ack,
  output logic [DataWidth-1:0] o_data
);

  rf_rd_state_e         r_state;
  logic [DataWidth-1:0] r_data;
  logic                 w_capture;

  always_comb begin
    w_capture = 1'b0;
    case (r_state)
      RD_IDLE: w_capture = i_req && !i_busy;
      RD_WAIT: w_capture = !i_busy;
      default: w_capture = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RD_IDLE;
      r_data  <= '0;
    end else begin
      case (r_state)
        RD_IDLE: if (i_req) r_state <= w_capture ? RD_RESP : RD_WAIT;
        RD_WAIT: if (w_capture) r_state <= RD_RESP;
        default: r_state <= RD_IDLE;
      endcase
      if (w_capture) r_data <= i_data;
    end
  end

  assign o_ack  = (r_state == RD_RESP);
  assign o_data = r_data;

endmodule

// File: rtl/register_file_lock.sv
// Register file with per-register lock scoreboard; reads stall on locked registers.
// Define RF_BYPASS_EN to forward same-cycle writeback data straight into waiting read ports.
module register_file_lock
  import register_file_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumWords  = 32,
  parameter int NumRead   = 2,
  parameter int NumSrc    = 2,
  localparam int SelW     = (NumSrc > 1) ? $clog2(NumSrc) : 1,
  localparam int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumRead-1:0]             rd_req_i,
  input  logic [NumRead*RF_ADDR_W-1:0]   rd_addr_i,
  output logic [NumRead-1:0]             rd_ack_o,
  output logic [NumRead*DataWidth-1:0]   rd_data_o,
  input  logic                           lock_req_i,
  input  logic [RF_ADDR_W-1:0]           lock_addr_i,
  output logic                           lock_ack_o,
  input  logic                           wr_req_i,
  input  logic [RF_ADDR_W-1:0]           wr_addr_i,
  input  logic [SelW-1:0]                wr_sel_i,
  input  logic [NumSrc*DataWidth-1:0]    wr_data_i,
  output logic                           wr_ack_o,
  output logic [NumWords-1:0]            busy_o
);

  logic [DataWidth-1:0] r_mem [NumWords];
  logic [NumWords-1:0]  r_busy;
  logic                 r_lock_ack;
  logic                 r_wr_ack;

  logic [NumWords-1:0]  w_busy_next;
  logic [DataWidth-1:0] w_wr_data;
  logic                 w_wr_null;
  logic                 w_wr_en;
  logic                 w_lock_null;
  logic                 w_lock_busy;
  logic                 w_lock_wr_hit;
  logic                 w_lock_grant;
  logic [IdxW-1:0]      w_wr_idx;
  logic [IdxW-1:0]      w_lock_idx;

  // Out-of-range source selects fall back to slice 0.
  always_comb begin
    w_wr_data = wr_data_i[0 +: DataWidth];
    for (int s = 1; s < NumSrc; s++) begin
      if (int'(wr_sel_i) == s) w_wr_data = wr_data_i[s*DataWidth +: DataWidth];
    end
  end

  assign w_wr_idx      = wr_addr_i[IdxW-1:0];
  assign w_lock_idx    = lock_addr_i[IdxW-1:0];
  assign w_wr_null     = is_null_reg(wr_addr_i, NumWords);
  assign w_lock_null   = is_null_reg(lock_addr_i, NumWords);
  assign w_wr_en       = wr_req_i && !w_wr_null;
  assign w_lock_busy   = !w_lock_null && r_busy[w_lock_idx];
  // A writeback to the same register wins this cycle; the lock is granted next cycle at the earliest.
  assign w_lock_wr_hit = w_wr_en && (wr_addr_i == lock_addr_i);
  assign w_lock_grant  = lock_req_i && !r_lock_ack && !w_lock_busy && !w_lock_wr_hit;

  always_comb begin
    w_busy_next = r_busy;
    if (w_lock_grant && !w_lock_null) w_busy_next[w_lock_idx] = 1'b1;
    if (w_wr_en) w_busy_next[w_wr_idx] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy     <= '0;
      r_lock_ack <= 1'b0;
      r_wr_ack   <= 1'b0;
    end else begin
      r_busy     <= w_busy_next;
      r_lock_ack <= w_lock_grant;
      r_wr_ack   <= wr_req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NumWords; w++) r_mem[w] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  genvar gi;
  for (gi = 0; gi < NumRead; gi++) begin : g_rd
    logic [RF_ADDR_W-1:0] w_addr;
    logic                 w_null;
    logic                 w_byp;
    logic                 w_busy;
    logic [DataWidth-1:0] w_data;
    logic                 w_ack;
    logic [DataWidth-1:0] w_port_data;

    assign w_addr = rd_addr_i[gi*RF_ADDR_W +: RF_ADDR_W];
    assign w_null = is_null_reg(w_addr, NumWords);
`ifdef RF_BYPASS_EN
    assign w_byp  = w_wr_en && (wr_addr_i == w_addr);
`else
    assign w_byp  = 1'b0;
`endif
    assign w_busy = !w_null && r_busy[w_addr[IdxW-1:0]] && !w_byp;
    assign w_data = w_byp ? w_wr_data : (w_null ? '0 : r_mem[w_addr[IdxW-1:0]]);

    rf_read_port #(
      .DataWidth(DataWidth)
    ) u_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_req  (rd_req_i[gi]),
      .i_busy (w_busy),
      .i_data (w_data),
      .o_ack  (w_ack),
      .o_data (w_port_data)
    );

    assign rd_ack_o[gi]                        = w_ack;
    assign rd_data_o[gi*DataWidth +: DataWidth] = w_port_data;
  end

  assign lock_ack_o = r_lock_ack;
  assign wr_ack_o   = r_wr_ack;
  assign busy_o     = r_busy;

endmodule
